// File: rtl/seq_sub_pkg.sv
// Shared definitions for the sequential subtractor: FSM state encoding,
// default operand/slice widths and the slice-counter width helper.
package seq_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_SLICE = 16;

    // Counter width for NSLICE slices; never narrower than one bit.
    function automatic int cnt_width(input int nslice);
        if (nslice <= 2) begin
            return 1;
        end
        return $clog2(nslice);
    endfunction

endpackage

// File: rtl/seq_sub_64bit_cla_slice.sv
// cla_slice: combinational SLICE-bit carry-lookahead adder, s = x + y + ci.
// Bits are grouped in fours; each group resolves its internal carries and
// its group generate/propagate, and group carries are chained by lookahead.
module cla_slice #(
    parameter int SLICE = 16
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co
);

    localparam int NG = SLICE / 4;

    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE-1:0] c;
    logic [NG:0]      gc;
    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;

    assign g = x & y;
    assign p = x | y;

    // Per-group lookahead terms and the group-carry chain.
    always_comb begin
        c     = '0;
        gc    = '0;
        grp_g = '0;
        grp_p = '0;
        gc[0] = ci;
        for (int j = 0; j < NG; j++) begin
            c[4*j]     = gc[j];
            c[4*j+1]   = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2]   = g[4*j+1] | (p[4*j+1] & g[4*j])
                       | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3]   = g[4*j+2] | (p[4*j+2] & g[4*j+1])
                       | (p[4*j+2] & p[4*j+1] & g[4*j])
                       | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
            grp_g[j]   = g[4*j+3] | (p[4*j+3] & g[4*j+2])
                       | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                       | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            grp_p[j]   = &p[4*j +: 4];
            gc[j+1]    = grp_g[j] | (grp_p[j] & gc[j]);
        end
    end

    assign s  = x ^ y ^ c;
    assign co = gc[NG];

endmodule

// File: rtl/seq_sub_64bit.sv
// seq_sub_64bit: multi-cycle subtractor, diff = a - b, computed as a + ~b + 1
// one SLICE-bit chunk per clock with the inter-slice carry held in a flop.
// Optional macro SEQ_SUB_OVF_EN adds the signed-overflow output ovf.
module seq_sub_64bit
    import seq_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
`ifdef SEQ_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = cnt_width(NSLICE);
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
`ifdef SEQ_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [SLICE-1:0] slice_x, slice_y, slice_s;
    logic             slice_co;

    assign slice_x = opa_q[cnt_q*SLICE +: SLICE];
    assign slice_y = opb_q[cnt_q*SLICE +: SLICE];

    cla_slice #(.SLICE(SLICE)) u_slice (
        .x  (slice_x),
        .y  (slice_y),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    // Next-state logic: operand capture, per-slice accumulate, final flags.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
`ifdef SEQ_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Subtrahend is stored inverted; carry-in of 1 completes ~b + 1.
                    opa_d   = a;
                    opb_d   = ~b;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                diff_d[cnt_q*SLICE +: SLICE] = slice_s;
                carry_d = slice_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    bout_d  = ~slice_co;
                    zero_d  = (diff_d == '0);
`ifdef SEQ_SUB_OVF_EN
                    // opb_q holds ~b, so the original b MSB is its inverse.
                    ovf_d   = (opa_q[WIDTH-1] != ~opb_q[WIDTH-1])
                            && (diff_d[WIDTH-1] != opa_q[WIDTH-1]);
`endif
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything and aborts a run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
`ifdef SEQ_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
`ifdef SEQ_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;
`ifdef SEQ_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_seq_sub_64bit.sv
// Self-checking bench for seq_sub_64bit with directed vectors and a
// randomized regression against a - b.
module tb_seq_sub_64bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        done;
    logic [63:0] diff;
    logic        bout;
    logic        zero;
`ifdef SEQ_SUB_OVF_EN
    logic        ovf;
`endif

    int n_checks;
    int n_pass;

    seq_sub_64bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
`ifdef SEQ_SUB_OVF_EN
        .ovf   (ovf),
`endif
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Starts one operation, scrambles a/b after the accept edge, and waits
    // (bounded) for done. lat counts edges from accept to done.
    task automatic do_sub(input logic [63:0] ta, input logic [63:0] tb_v,
                          output int lat, output int busy_cnt);
        @(negedge clk);
        a = ta;
        b = tb_v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~ta;
        b = {$urandom, $urandom};
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int bc;
        logic [63:0] ra;
        logic [63:0] rb;
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_diff", diff, 64'd0);
        check("reset_bout", 64'(bout), 64'd0);
        check("reset_zero", 64'(zero), 64'd0);
`ifdef SEQ_SUB_OVF_EN
        check("reset_ovf", 64'(ovf), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Abort mid-run with an asynchronous reset.
        @(negedge clk);
        a = 64'd5;
        b = 64'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("abort_busy_before", 64'(busy), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_diff", diff, 64'd0);
        check("abort_bout", 64'(bout), 64'd0);
        check("abort_zero", 64'(zero), 64'd0);
        check("abort_state", 64'(dut.state_q), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic subtraction with latency and busy-length checks.
        do_sub(64'd5, 64'd3, lat, bc);
        check("basic_lat", 64'(lat), 64'd4);
        check("basic_busy_cycles", 64'(bc), 64'd4);
        check("basic_diff", diff, 64'd2);
        check("basic_bout", 64'(bout), 64'd0);
        check("basic_zero", 64'(zero), 64'd0);
        check("basic_busy_in_done", 64'(busy), 64'd0);
`ifdef SEQ_SUB_OVF_EN
        check("basic_ovf", 64'(ovf), 64'd0);
`endif
        @(posedge clk);
        #1;
        check("done_one_cycle", 64'(done), 64'd0);
        check("diff_held", diff, 64'd2);

        do_sub(64'd0, 64'd1, lat, bc);
        check("wrap_lat", 64'(lat), 64'd4);
        check("wrap_diff", diff, 64'hFFFF_FFFF_FFFF_FFFF);
        check("wrap_bout", 64'(bout), 64'd1);
        check("wrap_zero", 64'(zero), 64'd0);

        do_sub(64'h0001_0000_0000_0000, 64'd1, lat, bc);
        check("ripple_diff", diff, 64'h0000_FFFF_FFFF_FFFF);
        check("ripple_bout", 64'(bout), 64'd0);

        do_sub(64'd1, 64'hFFFF_FFFF_FFFF_FFFF, lat, bc);
        check("small_minus_max_diff", diff, 64'd2);
        check("small_minus_max_bout", 64'(bout), 64'd1);

        do_sub(64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, lat, bc);
        check("equal_diff", diff, 64'd0);
        check("equal_zero", 64'(zero), 64'd1);
        check("equal_bout", 64'(bout), 64'd0);

        do_sub(64'h8000_0000_0000_0000, 64'd1, lat, bc);
        check("minint_diff", diff, 64'h7FFF_FFFF_FFFF_FFFF);
        check("minint_bout", 64'(bout), 64'd0);
`ifdef SEQ_SUB_OVF_EN
        check("minint_ovf", 64'(ovf), 64'd1);
`endif
        do_sub(64'd5, 64'd3, lat, bc);
`ifdef SEQ_SUB_OVF_EN
        check("ovf_clear", 64'(ovf), 64'd0);
`endif
        check("again_diff", diff, 64'd2);

        // start held high through RUN with changing operands, then a
        // back-to-back start accepted in the DONE cycle.
        @(negedge clk);
        while (done) @(negedge clk);
        a = 64'd100;
        b = 64'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        while (!done && lat < 20) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            @(posedge clk);
            #1;
            lat++;
        end
        check("held_lat", 64'(lat), 64'd4);
        check("held_diff", diff, 64'd99);
        a = 64'd10;
        b = 64'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy", 64'(busy), 64'd1);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b_lat", 64'(lat), 64'd4);
        check("b2b_diff", diff, 64'd6);

        // Randomized regression against the arithmetic reference.
        for (int i = 0; i < 1000; i++) begin
            ra = {$urandom, $urandom};
            rb = (i % 50 == 0) ? ra : {$urandom, $urandom};
            do_sub(ra, rb, lat, bc);
            check("rand_diff", diff, ra - rb);
            check("rand_bout", 64'(bout), 64'(ra < rb));
            check("rand_zero", 64'(zero), 64'(ra == rb));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_sub_64bit.md
Name: seq_sub_64bit

Overview:
- Multi-cycle 64-bit subtractor, diff = a - b, in the same arithmetic family as the 64-bit carry-lookahead adder.
- Computes a + ~b + 1 one SLICE-bit chunk per clock through a lookahead slice (4-bit g/p groups plus a group-carry generator).
- Inter-slice carry is held in a register.
- Sits beside the adder in the ALU datapath; controlled by a start/busy/done handshake.

Parameters:
- WIDTH, 64, operand and result width; must be a multiple of SLICE.
- SLICE, 16, bits processed per cycle; must be a multiple of 4; NSLICE = WIDTH/SLICE (default 4).

Ports:
- clk    input   1      rising-edge clock
- rst_n  input   1      asynchronous active-low reset
- start  input   1      request; sampled only when busy=0
- a      input   WIDTH  minuend; captured on accepted start
- b      input   WIDTH  subtrahend; captured on accepted start
- busy   output  1      high while in RUN
- done   output  1      one-cycle pulse when result is valid
- diff   output  WIDTH  a - b modulo 2^WIDTH; held until next accepted start
- bout   output  1      borrow out, 1 when a < b unsigned (= ~carry out of MSB)
- zero   output  1      1 when diff == 0; valid with done, held thereafter

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - state = IDLE; busy = 0, done = 0, diff = 0, bout = 0, zero = 0.
  - Slice counter = 0, carry register = 0, operand registers = 0.
  - Reset mid-RUN aborts the operation; the partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: capture a into opA and ~b into opB, set carry = 1, counter = 0, go to RUN.
  - start=0: remain in IDLE.
- RUN (busy=1):
  - Each edge: the slice adds opA[cnt*SLICE +: SLICE] + opB[same] + carry combinationally.
  - Writes diff[cnt*SLICE +: SLICE], loads carry with the slice carry-out, increments counter.
  - On the edge where counter = NSLICE-1: set bout = ~slice carry-out and zero = (full diff == 0, including the slice just written), go to DONE.
- DONE:
  - done = 1 for exactly one cycle, busy = 0.
  - start=1 in this cycle is accepted: capture and enter RUN, back-to-back.
  - Otherwise go to IDLE.
- start while busy=1 is ignored; it is not queued and operands are not recaptured.
- Latency: start accepted at edge k; done high during the cycle after edge k+NSLICE (4 cycles at defaults).
- diff is updated slice-by-slice during RUN and is only meaningful when done=1 or after it.
- a and b may change freely after the accepting edge.
- Arithmetic is modulo 2^WIDTH.
  - Wrap-around example: 0 - 1 = all ones with bout = 1.
  - a == b gives diff = 0, zero = 1, bout = 0.
- Slice internals:
  - Per bit: g = a&b, p = a|b.
  - Per 4-bit group: c1..c3 and group G/P are lookahead terms.
  - Group carries are chained by lookahead over the group G/P.
  - Sum bit = a^b^c.

Optional Feature:
- Macro: SEQ_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), reset 0, updated with bout.
  - ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), i.e. signed two's-complement overflow.
  - Requires capturing a[MSB] and b[MSB] at start.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package seq_sub_pkg:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Default WIDTH and SLICE constants.
  - Function computing the counter width, clog2(NSLICE) with a minimum of 1.
- Sub-module cla_slice: purely combinational SLICE-bit lookahead adder; inputs x, y, ci; outputs s, co.
- Top level holds the FSM, counter, operand/carry registers and flags.

Test Plan:
- Reset during RUN: start a=5, b=3, assert rst_n=0 after 2 cycles -> all outputs 0, state IDLE; a subsequent start completes normally.
- Basic subtraction: a=0x0000_0000_0000_0005, b=0x3 -> done 4 cycles after the accept edge, diff=0x2, bout=0, zero=0; busy high exactly 4 cycles.
- Borrow and wrap: a=0, b=1 -> diff=0xFFFF_FFFF_FFFF_FFFF, bout=1, zero=0.
  - Same check with a=0x0001_0000_0000_0000, b=0x1 -> diff=0x0000_FFFF_FFFF_FFFF, confirming the borrow ripples across all slice boundaries.
- Equal operands: a=b=0xDEAD_BEEF_CAFE_F00D -> diff=0, zero=1, bout=0.
- Handshake:
  - start held high through RUN with changing a/b -> only the first operands are used.
  - start=1 during the DONE cycle with a=10, b=4 -> second done exactly 4 cycles later, diff=6.
- With SEQ_SUB_OVF_EN:
  - a=0x8000_0000_0000_0000, b=1 -> ovf=1, diff=0x7FFF_FFFF_FFFF_FFFF.
  - a=5, b=3 -> ovf=0.
- Randomized regression: 1000 random a/b pairs checked against a reference model computing a-b.
